// File: rtl/l2cache_control_if.sv
// Bundle between the L2 control FSM and its neighbours:
// L1 arbiter, tag comparator, datapath and physical memory.
interface l2cache_control_if #(
  parameter int CNT_W = 16
);
  logic             mem_read;
  logic             mem_write;
  logic             mem_resp;
  logic             hit;
  logic             cmp_rst;
  logic             dirty_0;
  logic             dirty_1;
  logic             lru;
  logic             pmem_resp;
  logic             pmem_read;
  logic             pmem_write;
  logic             load_data_0;
  logic             load_data_1;
  logic             data_in_sel;
  logic             load_tag;
  logic             load_valid;
  logic             way_sel;
  logic             set_dirty;
  logic             clear_dirty;
  logic             load_lru;
  logic             lru_in;
  logic             pmem_addr_sel;
  logic [CNT_W-1:0] hit_count;
  logic [CNT_W-1:0] miss_count;

  modport master (
    output mem_read, mem_write, hit, cmp_rst,
    output dirty_0, dirty_1, lru, pmem_resp,
    input  mem_resp, pmem_read, pmem_write,
    input  load_data_0, load_data_1, data_in_sel,
    input  load_tag, load_valid, way_sel,
    input  set_dirty, clear_dirty, load_lru, lru_in,
    input  pmem_addr_sel, hit_count, miss_count
  );

  modport slave (
    input  mem_read, mem_write, hit, cmp_rst,
    input  dirty_0, dirty_1, lru, pmem_resp,
    output mem_resp, pmem_read, pmem_write,
    output load_data_0, load_data_1, data_in_sel,
    output load_tag, load_valid, way_sel,
    output set_dirty, clear_dirty, load_lru, lru_in,
    output pmem_addr_sel, hit_count, miss_count
  );
endinterface

// File: rtl/l2cache_control.sv
// Control FSM of the 2-way set-associative L2 cache:
// hit service, dirty writeback, line allocate, event counters.
module l2cache_control #(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  l2cache_control_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    WRITEBACK,
    ALLOCATE
  } state_t;

  state_t           state;
  logic             vway;
  logic             refill;
  logic [CNT_W-1:0] hit_q;
  logic [CNT_W-1:0] miss_q;
  logic             req;
  logic             vdirty;

  assign req    = bus.mem_read | bus.mem_write;
  assign vdirty = bus.lru ? bus.dirty_1 : bus.dirty_0;

  assign bus.hit_count  = hit_q;
  assign bus.miss_count = miss_q;

  // State, victim way, refill flag and event counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      vway   <= 1'b0;
      refill <= 1'b0;
      hit_q  <= '0;
      miss_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req) state <= CHECK;
        end
        CHECK: begin
          refill <= 1'b0;
          if (bus.hit) begin
            if (!refill) hit_q <= hit_q + 1'b1;
            state <= IDLE;
          end else begin
            vway   <= bus.lru;
            miss_q <= miss_q + 1'b1;
            state  <= vdirty ? WRITEBACK : ALLOCATE;
          end
        end
        WRITEBACK: begin
          if (bus.pmem_resp) state <= ALLOCATE;
        end
        ALLOCATE: begin
          if (bus.pmem_resp) begin
            refill <= 1'b1;
            state  <= CHECK;
          end
        end
      endcase
    end
  end

  // Datapath strobes and selects, decoded from state and inputs.
  always_comb begin
    bus.mem_resp      = 1'b0;
    bus.pmem_read     = 1'b0;
    bus.pmem_write    = 1'b0;
    bus.load_data_0   = 1'b0;
    bus.load_data_1   = 1'b0;
    bus.data_in_sel   = 1'b0;
    bus.load_tag      = 1'b0;
    bus.load_valid    = 1'b0;
    bus.way_sel       = 1'b0;
    bus.set_dirty     = 1'b0;
    bus.clear_dirty   = 1'b0;
    bus.load_lru      = 1'b0;
    bus.lru_in        = 1'b0;
    bus.pmem_addr_sel = 1'b0;
    unique case (state)
      IDLE: begin
      end
      CHECK: begin
        if (bus.hit) begin
          bus.way_sel  = bus.cmp_rst;
          bus.mem_resp = 1'b1;
          bus.load_lru = 1'b1;
          bus.lru_in   = ~bus.cmp_rst;
          if (bus.mem_write) begin
            bus.load_data_0 = ~bus.cmp_rst;
            bus.load_data_1 = bus.cmp_rst;
            bus.set_dirty   = 1'b1;
          end
        end
      end
      WRITEBACK: begin
        bus.pmem_write    = 1'b1;
        bus.pmem_addr_sel = 1'b1;
        bus.way_sel       = vway;
      end
      ALLOCATE: begin
        bus.pmem_read = 1'b1;
        bus.way_sel   = vway;
        if (bus.pmem_resp) begin
          bus.load_data_0 = ~vway;
          bus.load_data_1 = vway;
          bus.data_in_sel = 1'b1;
          bus.load_tag    = 1'b1;
          bus.load_valid  = 1'b1;
          bus.clear_dirty = 1'b1;
        end
      end
    endcase
  end

endmodule

// File: doc/l2cache_control.md
# l2cache_control

Control FSM for the 2-way set-associative L2 cache. It sits directly downstream of the L2 tag comparator and consumes its `hit` and `cmp_rst` (hit-way) outputs. It sequences hit service, dirty-victim writeback and line allocation between the L1-side arbiter and physical memory. It drives the datapath's way write-enables, tag/valid/dirty/LRU updates and mux selects, and keeps hit/miss event counters.

## Interface
- `CNT_W`, default 16: width of the hit and miss counters.

- `clk` input 1: sole clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `mem_read`, `mem_write` input 1 each: L1-side request. Held until `mem_resp`. If both are high, the request is a write.
- `mem_resp` output 1: request complete, one-cycle pulse.
- `hit` input 1: from the tag comparator.
- `cmp_rst` input 1: hit way (0 = way 0, 1 = way 1). Meaningful only when `hit` = 1.
- `dirty_0`, `dirty_1` input 1 each: dirty bits of the indexed set.
- `lru` input 1: way to evict next for the indexed set.
- `pmem_resp` input 1: physical memory done.
- `pmem_read`, `pmem_write` output 1 each: physical memory request.
- `load_data_0`, `load_data_1` output 1 each: way data-array write enables.
- `data_in_sel` output 1: 0 = upstream write data (merged), 1 = pmem line.
- `load_tag`, `load_valid` output 1 each: update the tag and set the valid bit of way `way_sel`.
- `way_sel` output 1: way addressed by the load strobes and by the read mux.
- `set_dirty`, `clear_dirty` output 1 each: dirty-bit update for `way_sel`.
- `load_lru` output 1: LRU write enable.
- `lru_in` output 1: new LRU value.
- `pmem_addr_sel` output 1: 0 = request address, 1 = victim tag plus index.
- `hit_count`, `miss_count` output `CNT_W` each: event counters.

## Operation
- States: IDLE, CHECK, WRITEBACK, ALLOCATE.
- IDLE
  - All strobes low.
  - Goes to CHECK when `mem_read | mem_write`.
- CHECK, when `hit` = 1
  - `way_sel` = `cmp_rst`.
  - `mem_resp` = 1.
  - `load_lru` = 1, `lru_in` = `~cmp_rst`.
  - On a write, also `load_data_<cmp_rst>` = 1, `data_in_sel` = 0, `set_dirty` = 1.
  - Next state IDLE.
  - `hit_count` increments, except on the re-check that follows an allocate.
- CHECK, when `hit` = 0
  - Victim register `vway` <= `lru`.
  - `miss_count` increments.
  - Next state is WRITEBACK if the victim's dirty bit (selected by `lru`) is 1, otherwise ALLOCATE.
- WRITEBACK
  - `pmem_write` = 1, `pmem_addr_sel` = 1, `way_sel` = `vway`.
  - Goes to ALLOCATE on `pmem_resp`.
- ALLOCATE
  - `pmem_read` = 1, `pmem_addr_sel` = 0, `way_sel` = `vway`.
  - On `pmem_resp`: `load_data_<vway>`, `data_in_sel` = 1, `load_tag`, `load_valid`, `clear_dirty` all pulse; next state CHECK.
  - A flag `refill` is set so the following CHECK hits without counting a second event.
- `vway` is captured once per miss, so LRU changes cannot move the victim mid-miss.
- Counters wrap modulo 2^`CNT_W`.
- All outputs are Mealy/Moore combinational from state and inputs; no output is registered except the counters.

## Timing
- Reset (async) clears all of the following:
  - state to IDLE, `vway` = 0, `refill` = 0;
  - every strobe and select, including `mem_resp`, `pmem_read` and `pmem_write`, to 0;
  - both counters to 0.
- Reset mid-WRITEBACK or mid-ALLOCATE drops `pmem_*` immediately, with no completion. A `pmem_resp` arriving after reset is ignored in IDLE.
- Hit: request seen in IDLE at cycle 0; `mem_resp` in cycle 1. Latency 2 edges, back in IDLE at edge 2.
- Clean miss, `pmem_resp` in cycle k:
  - ALLOCATE from cycle 2;
  - refill written at edge k+1;
  - CHECK in cycle k+1 with `mem_resp`.
- Dirty miss: WRITEBACK from cycle 2 until `pmem_resp`, then ALLOCATE the next cycle. `pmem_write` and `pmem_read` are never high together.
- `pmem_read`/`pmem_write` stay high through the `pmem_resp` cycle and go low on the following edge.
- Upstream must hold the request and address until `mem_resp`. A request deasserted early is undefined.
- A new request may be presented the cycle after `mem_resp`; it is seen in IDLE.

## Test plan
- Read hit way 1 (`hit`=1, `cmp_rst`=1, read) -> `mem_resp` in cycle 1, `load_lru`=1, `lru_in`=0, no data load, `hit_count`=1.
- Write hit way 0 -> `mem_resp`, `load_data_0`, `set_dirty`, `data_in_sel`=0 and `lru_in`=1 in the same cycle; `load_data_1`=0.
- Clean miss, `lru`=1, `dirty_1`=0, `pmem_resp` after 5 cycles -> no `pmem_write`; `pmem_read` for 5 cycles; `load_data_1`, `load_tag`, `clear_dirty` on the resp cycle; `mem_resp` next cycle; `miss_count`=1, `hit_count`=0.
- Dirty miss, `lru`=0, `dirty_0`=1 -> `pmem_write` with `pmem_addr_sel`=1 until resp, then `pmem_read`. Flip `lru` during WRITEBACK -> refill still targets way 0.
- Assert `rst` in the middle of ALLOCATE -> `pmem_read` low in the same cycle, state IDLE, counters 0, no `mem_resp`.
- `CNT_W`=4, 16 read hits -> `hit_count` wraps to 0.
